// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort stage and its frame gatherer.
package sort_pkg;

    // Per-buffer life cycle: collecting samples, or holding a closed frame.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } sort_gather_state_t;

    localparam int NUM_VALS_DEF = 5;
    localparam int SIZE_DEF     = 16;

    // Width of a sample counter able to hold 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sort_frame_buf.sv
// One frame register: lane write index/count plus a FILL/FULL state machine.
// A closed frame is held unchanged until it is taken, then cleared to zero so
// unwritten lanes of the next partial frame read as zero padding.
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter  int NUM_VALS = NUM_VALS_DEF,
    parameter  int SIZE     = SIZE_DEF,
    localparam int CW       = count_width(NUM_VALS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fill,
    input  logic [SIZE-1:0]          fill_data,
    input  logic                     flush,
    input  logic                     take,
    output logic                     full,
    output logic [NUM_VALS*SIZE-1:0] data,
    output logic [CW-1:0]            count
);

    sort_gather_state_t          state_r, state_s;
    logic [CW-1:0]               count_r, count_s;
    logic [NUM_VALS*SIZE-1:0]    data_r,  data_s;

    // Next-state, lane write and count update for the frame buffer.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        data_s  = data_r;
        case (state_r)
            FILL: begin
                if (fill) begin
                    for (int k = 0; k < NUM_VALS; k++) begin
                        if (count_r == CW'(k)) begin
                            data_s[k*SIZE +: SIZE] = fill_data;
                        end else begin
                            data_s[k*SIZE +: SIZE] = data_r[k*SIZE +: SIZE];
                        end
                    end
                    count_s = count_r + CW'(1);
                    // A flush arriving with a sample closes after that sample.
                    if (flush || (count_r == CW'(NUM_VALS - 1))) begin
                        state_s = FULL;
                    end else begin
                        state_s = FILL;
                    end
                end else if (flush && (count_r != {CW{1'b0}})) begin
                    state_s = FULL;
                end else begin
                    state_s = FILL;
                end
            end
            FULL: begin
                if (take) begin
                    state_s = FILL;
                    count_s = {CW{1'b0}};
                    data_s  = {(NUM_VALS*SIZE){1'b0}};
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = FILL;
                count_s = {CW{1'b0}};
                data_s  = {(NUM_VALS*SIZE){1'b0}};
            end
        endcase
    end

    // State, count and frame registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FILL;
            count_r <= {CW{1'b0}};
            data_r  <= {(NUM_VALS*SIZE){1'b0}};
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            data_r  <= data_s;
        end
    end

    assign full  = (state_r == FULL);
    assign data  = data_r;
    assign count = count_r;

endmodule

// File: rtl/sort_frame_gather.sv
// Gathers a serial sample stream into NUM_VALS-lane frames for the sort stage.
// Optional macro SORT_GATHER_PINGPONG_EN: two alternating frame buffers so the
// input keeps flowing while a closed frame waits for the downstream handshake.
module sort_frame_gather
    import sort_pkg::*;
#(
    parameter  int NUM_VALS = NUM_VALS_DEF,
    parameter  int SIZE     = SIZE_DEF,
    localparam int CW       = count_width(NUM_VALS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [SIZE-1:0]          i_data,
    input  logic                     i_flush,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic [NUM_VALS*SIZE-1:0] o_frame_data,
    output logic [CW-1:0]            o_frame_count
);

    logic accept_s;
    logic flush_s;
    logic take_s;

    // Flush is only honoured while a buffer can accept; otherwise it is dropped.
    assign accept_s = i_valid & o_ready;
    assign flush_s  = i_flush & o_ready;
    assign take_s   = o_frame_valid & i_frame_ready;

`ifdef SORT_GATHER_PINGPONG_EN

    logic                     full_s  [2];
    logic [NUM_VALS*SIZE-1:0] data_s  [2];
    logic [CW-1:0]            count_s [2];
    logic                     wr_sel_r;
    logic                     rd_sel_r;
    logic                     wr_eff_s;

    // Once the write buffer closes, writing moves to the other buffer.
    assign wr_eff_s      = full_s[wr_sel_r] ? ~wr_sel_r : wr_sel_r;
    assign o_ready       = ~full_s[wr_eff_s] & ~i_rst;
    assign o_frame_valid = full_s[rd_sel_r];
    assign o_frame_data  = data_s[rd_sel_r];
    assign o_frame_count = count_s[rd_sel_r];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        sort_frame_buf #(
            .NUM_VALS (NUM_VALS),
            .SIZE     (SIZE)
        ) u_buf (
            .clk       (i_clk),
            .rst       (i_rst),
            .fill      (accept_s && (wr_eff_s == 1'(b))),
            .fill_data (i_data),
            .flush     (flush_s && (wr_eff_s == 1'(b))),
            .take      (take_s && (rd_sel_r == 1'(b))),
            .full      (full_s[b]),
            .data      (data_s[b]),
            .count     (count_s[b])
        );
    end

    // Write/read selects: reads alternate per handshake, keeping fill order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
        end else begin
            wr_sel_r <= wr_eff_s;
            rd_sel_r <= rd_sel_r ^ take_s;
        end
    end

`else

    logic full_s;

    assign o_ready       = ~full_s & ~i_rst;
    assign o_frame_valid = full_s;

    sort_frame_buf #(
        .NUM_VALS (NUM_VALS),
        .SIZE     (SIZE)
    ) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .fill      (accept_s),
        .fill_data (i_data),
        .flush     (flush_s),
        .take      (take_s),
        .full      (full_s),
        .data      (o_frame_data),
        .count     (o_frame_count)
    );

`endif

endmodule

// File: tb/tb_sort_frame_gather.sv
// Self-checking bench for sort_frame_gather: directed scenarios plus random
// traffic, compared against a frame-queue reference model.
module tb_sort_frame_gather;

    localparam int N  = 5;
    localparam int W  = 16;
    localparam int CW = $clog2(N + 1);
`ifdef SORT_GATHER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [W-1:0]     i_data;
    logic             i_flush;
    logic             o_frame_valid;
    logic             i_frame_ready;
    logic [N*W-1:0]   o_frame_data;
    logic [CW-1:0]    o_frame_count;

    always #5 i_clk = ~i_clk;

    sort_frame_gather #(.NUM_VALS(N), .SIZE(W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .i_flush       (i_flush),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame_data  (o_frame_data),
        .o_frame_count (o_frame_count)
    );

    typedef struct {
        logic [N*W-1:0] data;
        logic [CW-1:0]  count;
    } frame_t;

    frame_t       pend[$];   // closed frames awaiting handshake, oldest first
    logic [W-1:0] part[$];   // samples of the frame being collected
    int checks   = 0;
    int failures = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic frame_t pack_part();
        frame_t f;
        f.data = '0;
        for (int k = 0; k < part.size(); k++) f.data[k*W +: W] = part[k];
        f.count = CW'(part.size());
        return f;
    endfunction

    // Apply one cycle of inputs, compare outputs with the model, advance both.
    task automatic step(input logic v, input logic [W-1:0] d, input logic fl,
                        input logic fr, input logic r);
        logic exp_ready;
        logic exp_valid;
        i_valid = v; i_data = d; i_flush = fl; i_frame_ready = fr; i_rst = r;
        #1;
        exp_ready = !r && (pend.size() < CAP);
        exp_valid = (pend.size() > 0);
        check_bit("ready", o_ready, exp_ready);
        check_bit("frame_valid", o_frame_valid, exp_valid);
        if (exp_valid) begin
            check_vec("frame_data", o_frame_data, pend[0].data);
            check_cnt("frame_count", o_frame_count, pend[0].count);
        end
        if (r) begin
            pend.delete();
            part.delete();
        end else begin
            if (exp_valid && fr) void'(pend.pop_front());
            if (exp_ready) begin
                if (v) part.push_back(d);
                if ((part.size() == N) || (fl && (part.size() > 0))) begin
                    pend.push_back(pack_part());
                    part.delete();
                end
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, fr, 1'b0);
    endtask

    initial begin
        int accepted;
        logic [W-1:0] vals [5];
        i_rst = 1'b1; i_valid = 1'b0; i_data = 16'h0000; i_flush = 1'b0; i_frame_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        // Reset values
        check_bit("rst_ready", o_ready, 1'b0);
        check_bit("rst_valid", o_frame_valid, 1'b0);
        check_vec("rst_data", o_frame_data, 80'h0);
        check_cnt("rst_count", o_frame_count, 3'd0);
        i_rst = 1'b0;
        #1;
        check_bit("post_rst_ready", o_ready, 1'b1);

        // Full frame, back-to-back
        vals = '{16'h0003, 16'h0009, 16'h0001, 16'h0007, 16'h0005};
        for (int i = 0; i < 5; i++) step(1'b1, vals[i], 1'b0, 1'b1, 1'b0);
        check_vec("full_data", o_frame_data, 80'h0005_0007_0001_0009_0003);
        check_cnt("full_count", o_frame_count, 3'd5);
        check_bit("full_ready_low", o_ready, (CAP == 1) ? 1'b0 : 1'b1);
        idle(1, 1'b1);
        check_bit("full_ready_back", o_ready, 1'b1);
        check_bit("full_taken", o_frame_valid, 1'b0);

        // Flush of a partial frame, then flush with nothing collected
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check_vec("flush_data", o_frame_data, 80'h0000_0000_0000_00BB_00AA);
        check_cnt("flush_count", o_frame_count, 3'd2);
        idle(1, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check_bit("empty_flush", o_frame_valid, 1'b0);

        // Flush arriving together with the third sample
        step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00CC, 1'b1, 1'b0, 1'b0);
        check_cnt("flush_sample_count", o_frame_count, 3'd3);
        check_vec("flush_sample_lane2", {64'h0, o_frame_data[2*W +: W]}, 80'h00CC);
        idle(2, 1'b1);

        // Backpressure for 10 cycles while the source keeps offering samples
        for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, W'($urandom), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check_bit("midrst_no_frame", o_frame_valid, 1'b0);
        check_cnt("midrst_count", o_frame_count, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        check_cnt("midrst_clean_count", o_frame_count, 3'd5);
        idle(2, 1'b1);

`ifdef SORT_GATHER_PINGPONG_EN
        // Continuous stream never stalls when the sink is always ready
        for (int i = 0; i < 20; i++) begin
            check_bit("pp_stream_ready", o_ready, 1'b1);
            step(1'b1, W'($urandom), 1'b0, 1'b1, 1'b0);
        end
        idle(2, 1'b1);
        // With the sink stalled, the input stops after two full frames
        accepted = 0;
        for (int i = 0; i < 15; i++) begin
            if (o_ready === 1'b1) accepted++;
            step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check_cnt("pp_accept_limit", CW'(accepted > 7 ? accepted - 5 : 0), 3'd5);
        idle(4, 1'b1);
`else
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_ready === 1'b1) accepted++;
            step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check_cnt("sb_accept_limit", CW'(accepted), 3'd5);
        idle(2, 1'b1);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, W'($urandom), ($urandom % 8) == 0,
                 ($urandom % 4) != 0, 1'b0);
        end
        idle(6, 1'b1);
        check_bit("drained", o_frame_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_frame_gather.md
# sort_frame_gather

Upstream feeder for the single-cycle `sort` stage. It collects a serial stream of SIZE-bit samples into NUM_VALS-lane frames and zero-pads partial frames on flush. Each completed frame is presented on a valid/ready port whose data bus matches the `i_data` bus of `sort`. The sorter orders descending, so zero padding always settles in the low-rank lanes.

## Interface
- `NUM_VALS`, 5, lanes per frame (≥2)
- `SIZE`, 16, bits per sample
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; synchronous, active-high
- `i_valid`  in  1  input sample valid
- `o_ready`  out  1  input sample accepted when `i_valid & o_ready`
- `i_data`  in  SIZE  input sample
- `i_flush`  in  1  close the current partial frame
- `o_frame_valid`  out  1  frame available
- `i_frame_ready`  in  1  downstream takes frame when `o_frame_valid & i_frame_ready`
- `o_frame_data`  out  NUM_VALS*SIZE  frame; lane k = bits [k*SIZE +: SIZE]
- `o_frame_count`  out  $clog2(NUM_VALS+1)  real samples in frame (1..NUM_VALS)

## Operation
- FSM per frame buffer: FILL, FULL. Reset → FILL, count 0, buffer all-zero.
- FILL: `o_ready`=1. Each accepted sample is written to lane[count], then count++.
- Accepting the sample that makes count==NUM_VALS → FULL.
- `i_flush` in FILL with count>0 → FULL with the current count. Unwritten lanes stay 0.
- `i_flush` in FILL with count==0 is ignored (no empty frames).
- `i_flush` together with an accepted sample: the sample is written first, then the frame closes with count+1.
- `i_flush` in FULL is ignored and not remembered.
- FULL: `o_frame_valid`=1, and `o_frame_data`/`o_frame_count` are held stable until the handshake.
- FULL with handshake → FILL, count 0, buffer cleared to zero.
- `i_rst` mid-frame: partial data is discarded, no frame is emitted, and all state returns to reset values the next cycle.
- Reset values: `o_ready`=0 while `i_rst`=1 and 1 on the first cycle after; `o_frame_valid`=0; `o_frame_data`=0; `o_frame_count`=0.

## Timing
- All state is registered. `o_ready` and `o_frame_valid` decode registered state only, with no combinational path from `i_frame_ready` or `i_valid`.
- A frame becomes valid the cycle after its last sample or flush is accepted.
- Single-buffer throughput is one frame per NUM_VALS+1 cycles at best: `o_ready`=0 for at least one cycle per frame.
- Total latency to sorted output = 1 cycle (gather) + 1 cycle (`sort` output register).

## Configuration
- `SORT_GATHER_PINGPONG_EN` defined:
  - Two frame buffers, A and B.
  - Filling alternates A, B, A, ...
  - While one buffer is FULL, the other continues to fill. `o_ready`=0 only when both are FULL.
  - Frames are emitted strictly in fill order.
  - Sustained throughput is one sample per cycle when `i_frame_ready`=1.
- Not defined: one buffer, behaviour exactly as above.
- The port list is identical in both builds.

## Structure
- `sort_pkg`:
  - state enum `sort_gather_state_t` {FILL, FULL}.
  - `localparam` helper for count width `$clog2(NUM_VALS+1)`.
- Sub-module `sort_frame_buf`: one frame register, its lane write index, count and FSM. It has fill/flush/take inputs and full/data/count outputs. The top instantiates one copy, or two under `SORT_GATHER_PINGPONG_EN` plus write/read select flops.

## Test plan
- Full frame: NUM_VALS=5, SIZE=16. Send 0x0003, 0x0009, 0x0001, 0x0007, 0x0005 back-to-back with `i_frame_ready`=1.
  - Next cycle `o_frame_valid`=1, `o_frame_data`=0x0005_0007_0001_0009_0003, `o_frame_count`=5.
  - Single build: `o_ready`=0 for exactly 1 cycle.
- Flush partial: send 0x00AA, 0x00BB, then `i_flush` alone → frame 0x0000_0000_0000_00BB_00AA, count 2. With `i_flush`=1 at count 0 → no frame.
- Flush with sample: `i_flush` and the third sample 0x00CC in the same cycle → count 3, lane 2 = 0x00CC.
- Backpressure: hold `i_frame_ready`=0 for 10 cycles after a frame completes → data/count stable, `o_ready`=0 (single build), no sample lost. Release → handshake, next frame fills from lane 0.
- Reset mid-frame: accept 3 samples, pulse `i_rst` for 1 cycle → no `o_frame_valid`. The next 5 samples form a clean frame with count 5.
- `SORT_GATHER_PINGPONG_EN`: stream 20 samples continuously with `i_frame_ready`=1 → 4 frames in order, `o_ready` never low. With `i_frame_ready`=0 → `o_ready` drops after the 10th accepted sample.
